spi_burst_arb: RTL and testbench
================================

# spi_burst_arb

Arbitrated burst sequencer that shares one `spi_master` engine between REQS requesters. It grants a requester, owns chip-select for that requester's whole multi-byte burst, and issues one `enable` pulse per byte to the engine. It then returns each received byte to the granted requester. It sits between the SPI engine and its clients: the Wishbone SPI front-end, the radio packet engine, and the IMU poller.

## Interface
- REQS, 2: number of requesters (2..4).
- DW, 8: byte width; must equal the engine's d_width.
- CS_SETUP, 2: clk cycles from csn low to first enable (≥1).
- CS_HOLD, 2: clk cycles from last byte done to csn high (≥1).
- CS_GAP, 4: minimum clk cycles csn stays high between bursts (≥1).
- START_TMO, 15: max clk cycles waiting for engine busy to rise after enable.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  REQS  request burst, level; held until burst ends.
- gnt  out  REQS  one-hot grant, held for entire burst.
- tx_valid  in  REQS  per-requester byte valid (only granted bit honoured).
- tx_last  in  REQS  marks final byte of burst.
- tx_data  in  REQS*DW  per-requester byte, slice i = [i*DW +: DW].
- tx_ready  out  1  byte accepted this cycle (to granted requester).
- rx_valid  out  REQS  one-cycle pulse, received byte for that requester.
- rx_data  out  DW  received byte, valid with rx_valid.
- err  out  1  one-cycle pulse: engine failed to start (timeout).
- csn  out  1  chip-select, active low.
- spi_enable  out  1  start strobe to engine.
- spi_tx_data  out  DW  byte to engine.
- spi_busy  in  1  engine busy.
- spi_rx_data  in  DW  engine received byte.

## Operation
- Reset values: gnt=0, tx_ready=0, rx_valid=0, rx_data=0, err=0, csn=1, spi_enable=0, spi_tx_data=0, state=IDLE, rr pointer=REQS-1 (requester 0 wins first).
- Arbitration: round-robin. Search starts at pointer+1 and wraps; the pointer updates to the granted index when the grant is issued. A req dropped mid-burst is ignored; the burst ends only on tx_last or error.
- States:
  - IDLE: when any req is high, register gnt and go to SETUP.
  - SETUP: csn=0; count CS_SETUP cycles, then go to WAIT_TX.
  - WAIT_TX: tx_ready=1. When the granted tx_valid is high, latch the byte into spi_tx_data, latch tx_last into last_f, go to KICK. tx_ready is a registered output, so a byte is accepted only when tx_ready and tx_valid are both high on the same edge.
  - KICK: spi_enable=1 for exactly one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: on spi_busy=1 go to XFER. If the counter reaches START_TMO, pulse err and go to HOLD, treating the burst as ended.
  - XFER: on spi_busy=0, capture spi_rx_data into rx_data and pulse rx_valid[granted]. If last_f, go to HOLD; otherwise go to WAIT_TX.
  - HOLD: keep csn=0 for CS_HOLD cycles, then csn=1, clear gnt, go to GAP.
  - GAP: csn=1 for CS_GAP cycles, then go to IDLE. The new grant is evaluated in IDLE.
- Whenever csn is high, spi_tx_data holds its last value.
- A new req arriving during any state other than IDLE waits. gnt never changes while csn=0.
- Async reset mid-burst: all outputs return to reset values immediately; csn goes high asynchronously. The engine is reset by the same net.

## Timing
- Grant latency: req rises at cycle t → gnt and csn=0 at t+1 (from IDLE, no gap pending).
- First enable at t+1+CS_SETUP+1 if tx_valid is already high. The cycle sequence is SETUP×CS_SETUP, WAIT_TX×1, then KICK.
- Per-byte overhead outside the engine: 3 cycles (WAIT_TX, KICK, XFER exit), plus the engine transfer time.
- rx_valid fires in the cycle after spi_busy is first sampled low in XFER.
- Between back-to-back bursts from different requesters, csn stays high for exactly CS_GAP cycles plus 1 IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single burst: req0, 3 bytes 0xA5, 0x3C, 0x0F with last on the third. Required: one csn low window; 3 spi_enable pulses with the matching spi_tx_data; 3 rx_valid[0] pulses echoing the loopback engine data; csn high CS_HOLD cycles after the third rx_valid.
- Round-robin: req0 and req1 asserted together and re-requesting continuously with 1-byte bursts. Required: grants alternate 0,1,0,1 and csn is high ≥CS_GAP+1 cycles between bursts.
- Throttled source: tx_valid low for 10 cycles between bytes. Required: csn stays low and no extra spi_enable pulses occur; the FSM waits in WAIT_TX.
- Start timeout: engine stub never raises busy. Required: err pulses exactly START_TMO cycles after KICK; csn returns high after CS_HOLD; no rx_valid.
- Reset mid-transfer: reset_n pulled low while in XFER. Required: csn=1, gnt=0, spi_enable=0 asynchronously. After release, a req1 burst completes normally with requester 0 still having first priority.
- Late request: req1 rises during req0's burst. Required: gnt stays 01 until csn goes high, then gnt=10 after the gap.

Source files
------------

// File: rtl/spi_burst_arb_if.sv
// Client and engine signals of the SPI burst arbiter.
// The master modport is the arbiter's view; slave is the clients plus engine.
interface spi_burst_arb_if #(
  parameter int REQS = 2,
  parameter int DW   = 8
);
  logic [REQS-1:0]    req;
  logic [REQS-1:0]    gnt;
  logic [REQS-1:0]    tx_valid;
  logic [REQS-1:0]    tx_last;
  logic [REQS*DW-1:0] tx_data;
  logic               tx_ready;
  logic [REQS-1:0]    rx_valid;
  logic [DW-1:0]      rx_data;
  logic               err;
  logic               csn;
  logic               spi_enable;
  logic [DW-1:0]      spi_tx_data;
  logic               spi_busy;
  logic [DW-1:0]      spi_rx_data;

  modport master (
    input  req, tx_valid, tx_last, tx_data, spi_busy, spi_rx_data,
    output gnt, tx_ready, rx_valid, rx_data, err, csn, spi_enable, spi_tx_data
  );

  modport slave (
    output req, tx_valid, tx_last, tx_data, spi_busy, spi_rx_data,
    input  gnt, tx_ready, rx_valid, rx_data, err, csn, spi_enable, spi_tx_data
  );
endinterface

// File: rtl/spi_burst_arb.sv
// Round-robin burst sequencer sharing one SPI engine between REQS clients.
// Owns chip-select for a whole burst and strobes the engine once per byte.
module spi_burst_arb #(
  parameter int REQS      = 2,
  parameter int DW        = 8,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_GAP    = 4,
  parameter int START_TMO = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_burst_arb_if.master   bus
);
  localparam int PW = (REQS > 1) ? $clog2(REQS) : 1;
  localparam int CW = 8;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(START_TMO - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, WAIT_TX, KICK, WAIT_BUSY, XFER, HOLD, GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_q, rr_d, sel_q, sel_d;
  logic [REQS-1:0] gnt_q, gnt_d, rx_valid_q, rx_valid_d;
  logic            tx_ready_q, tx_ready_d, err_q, err_d;
  logic            csn_q, csn_d, en_q, en_d, last_q, last_d;
  logic [DW-1:0]   rx_data_q, rx_data_d, tx_byte_q, tx_byte_d;
  logic            pick_any;
  logic [PW-1:0]   pick_idx;
  int              idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = rr_q;
    idx      = 0;
    for (int i = 1; i <= REQS; i++) begin
      idx = (int'(rr_q) + i) % REQS;
      if (!pick_any && bus.req[idx]) begin
        pick_any = 1'b1;
        pick_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    tx_ready_d = tx_ready_q;
    csn_d      = csn_q;
    last_d     = last_q;
    rx_data_d  = rx_data_q;
    tx_byte_d  = tx_byte_q;
    rx_valid_d = '0;
    err_d      = 1'b0;
    en_d       = 1'b0;

    unique case (state_q)
      IDLE: if (pick_any) begin
        gnt_d           = '0;
        gnt_d[pick_idx] = 1'b1;
        sel_d           = pick_idx;
        rr_d            = pick_idx;
        csn_d           = 1'b0;
        cnt_d           = '0;
        state_d         = SETUP;
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d      = '0;
          tx_ready_d = 1'b1;
          state_d    = WAIT_TX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_TX: if (tx_ready_q && bus.tx_valid[sel_q]) begin
        tx_byte_d  = bus.tx_data[int'(sel_q)*DW +: DW];
        last_d     = bus.tx_last[sel_q];
        tx_ready_d = 1'b0;
        en_d       = 1'b1;
        state_d    = KICK;
      end
      KICK: begin
        // Counter tracks cycles since the strobe so the timeout lands START_TMO after it.
        cnt_d   = CW'(1);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.spi_busy) begin
          cnt_d   = '0;
          state_d = XFER;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: if (!bus.spi_busy) begin
        rx_data_d  = bus.spi_rx_data;
        rx_valid_d = gnt_q;
        if (last_q) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          tx_ready_d = 1'b1;
          state_d    = WAIT_TX;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          csn_d   = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= PW'(REQS - 1);
      sel_q      <= '0;
      gnt_q      <= '0;
      tx_ready_q <= 1'b0;
      csn_q      <= 1'b1;
      last_q     <= 1'b0;
      rx_data_q  <= '0;
      tx_byte_q  <= '0;
      rx_valid_q <= '0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values computed above.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      tx_ready_q <= tx_ready_d;
      csn_q      <= csn_d;
      last_q     <= last_d;
      rx_data_q  <= rx_data_d;
      tx_byte_q  <= tx_byte_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      en_q       <= en_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.err         = err_q;
  assign bus.csn         = csn_q;
  assign bus.spi_enable  = en_q;
  assign bus.spi_tx_data = tx_byte_q;
endmodule

// File: tb/tb_spi_burst_arb.sv
// Directed bench for spi_burst_arb with an inverting loopback engine stub.
// Monitors log enable/rx/err events with cycle stamps for timing checks.
module tb_spi_burst_arb;
  localparam int ENG_LEN = 4;
  localparam int CS_HOLD = 2;
  localparam int CS_GAP  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stub_dead = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   csn_rise = 0;
  logic csn_prev = 1'b1;
  logic [7:0] burst [0:3];

  logic [7:0] en_dat_q [$];
  int         en_cyc_q [$];
  logic [1:0] rx_vec_q [$];
  logic [7:0] rx_dat_q [$];
  int         rx_cyc_q [$];
  int         err_cyc_q [$];

  spi_burst_arb_if #(.REQS(2), .DW(8)) bus ();

  spi_burst_arb #(
    .REQS(2), .DW(8), .CS_SETUP(2), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP), .START_TMO(15)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Engine stub: busy for ENG_LEN cycles after a strobe, returns the inverted byte.
  logic       eng_busy;
  int         eng_cnt;
  logic [7:0] eng_data;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
      eng_data <= 8'h00;
    end else if (!eng_busy) begin
      if (bus.spi_enable && !stub_dead) begin
        eng_busy <= 1'b1;
        eng_cnt  <= ENG_LEN;
        eng_data <= ~bus.spi_tx_data;
      end
    end else if (eng_cnt <= 1) begin
      eng_busy <= 1'b0;
    end else begin
      eng_cnt <= eng_cnt - 1;
    end
  end
  assign bus.spi_busy    = eng_busy;
  assign bus.spi_rx_data = eng_data;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    csn_prev <= bus.csn;
    if (bus.csn && !csn_prev) csn_rise <= csn_rise + 1;
    if (bus.spi_enable) begin
      en_dat_q.push_back(bus.spi_tx_data);
      en_cyc_q.push_back(cyc);
    end
    if (bus.rx_valid != 2'b00) begin
      rx_vec_q.push_back(bus.rx_valid);
      rx_dat_q.push_back(bus.rx_data);
      rx_cyc_q.push_back(cyc);
    end
    if (bus.err) err_cyc_q.push_back(cyc);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (bus.gnt == 2'b00 && n < 200) begin
      tick();
      n++;
    end
    check({tag, " grant reached"}, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_csn_high(input string tag);
    int n;
    n = 0;
    while (bus.csn == 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, " csn release reached"}, 32'(n < 200), 32'd1);
  endtask

  task automatic send_burst(input int r, input int nbytes, input int throttle);
    for (int i = 0; i < nbytes; i++) begin
      int n;
      n = 0;
      bus.tx_data[r*8 +: 8] = burst[i];
      bus.tx_valid[r]       = 1'b1;
      bus.tx_last[r]        = (i == nbytes - 1);
      while (!bus.tx_ready && n < 200) begin
        tick();
        n++;
      end
      check("byte accepted", 32'(n < 200), 32'd1);
      tick();
      bus.tx_valid[r] = 1'b0;
      bus.tx_last[r]  = 1'b0;
      if (i < nbytes - 1 && throttle > 0) begin
        repeat (throttle) tick();
        check("throttle csn low", 32'(bus.csn), 32'd0);
        check("throttle waits in WAIT_TX", 32'(bus.tx_ready), 32'd1);
      end
    end
  endtask

  initial begin
    int t, e0, r0, c0, k0, rise, fall, r;
    bus.req = 2'b00;
    bus.tx_valid = 2'b00;
    bus.tx_last = 2'b00;
    bus.tx_data = 16'h0000;

    // Reset values
    repeat (3) tick();
    check("reset gnt", 32'(bus.gnt), 32'd0);
    check("reset csn", 32'(bus.csn), 32'd1);
    check("reset tx_ready", 32'(bus.tx_ready), 32'd0);
    check("reset spi_enable", 32'(bus.spi_enable), 32'd0);
    check("reset rx_valid/err", 32'({bus.rx_valid, bus.err}), 32'd0);
    check("reset data", 32'({bus.rx_data, bus.spi_tx_data}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single 3-byte burst from requester 0
    burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'h0F;
    e0 = en_cyc_q.size(); r0 = rx_cyc_q.size(); c0 = csn_rise;
    t = cyc;
    bus.req[0] = 1'b1;
    tick();
    check("grant latency gnt", 32'(bus.gnt), 32'd1);
    check("grant latency csn", 32'(bus.csn), 32'd0);
    send_burst(0, 3, 0);
    bus.req[0] = 1'b0;
    wait_csn_high("single");
    rise = cyc;
    tick(); tick();
    check("single enable count", 32'(en_cyc_q.size() - e0), 32'd3);
    check("single first enable cycle", 32'(en_cyc_q[e0] - t), 32'd4);
    check("single enable spacing", 32'(en_cyc_q[e0+1] - en_cyc_q[e0]), 32'(ENG_LEN + 3));
    check("single tx byte 0", 32'(en_dat_q[e0]), 32'hA5);
    check("single tx byte 1", 32'(en_dat_q[e0+1]), 32'h3C);
    check("single tx byte 2", 32'(en_dat_q[e0+2]), 32'h0F);
    check("single rx count", 32'(rx_cyc_q.size() - r0), 32'd3);
    check("single rx latency", 32'(rx_cyc_q[r0] - en_cyc_q[e0]), 32'(ENG_LEN + 2));
    check("single rx vec", 32'({rx_vec_q[r0], rx_vec_q[r0+1], rx_vec_q[r0+2]}), 32'b010101);
    check("single rx data", 32'({rx_dat_q[r0], rx_dat_q[r0+1], rx_dat_q[r0+2]}), 32'h5AC3F0);
    check("single csn hold", 32'(rise - rx_cyc_q[r0+2]), 32'(CS_HOLD));
    check("single one csn window", 32'(csn_rise - c0), 32'd1);
    check("single tx data held", 32'(bus.spi_tx_data), 32'h0F);

    // Late request: req1 rises while req0 still owns csn
    burst[0] = 8'h66; burst[1] = 8'h77;
    bus.req[0] = 1'b1;
    tick();
    send_burst(0, 2, 0);
    bus.req[1] = 1'b1;
    tick();
    check("late gnt held", 32'({bus.csn, bus.gnt}), 32'b001);
    bus.req[0] = 1'b0;
    wait_csn_high("late");
    rise = cyc;
    check("late gnt cleared at csn high", 32'(bus.gnt), 32'd0);
    wait_gnt("late");
    fall = cyc;
    check("late second grant", 32'(bus.gnt), 32'b10);
    check("late csn high cycles", 32'(fall - rise), 32'(CS_GAP + 1));
    r0 = rx_cyc_q.size();
    burst[0] = 8'h88;
    send_burst(1, 1, 0);
    bus.req[1] = 1'b0;
    wait_csn_high("late b1");
    tick(); tick();
    check("late rx to requester 1", 32'({rx_vec_q[r0], rx_dat_q[r0]}), 32'h277);

    // Round-robin with both requesters always requesting
    bus.req = 2'b11;
    rise = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt("rr");
      fall = cyc;
      check("rr grant order", 32'(bus.gnt), 32'(2'b01 << (i % 2)));
      if (i > 0) check("rr csn gap", 32'(fall - rise), 32'(CS_GAP + 1));
      r = bus.gnt[1] ? 1 : 0;
      burst[0] = 8'h10 + 8'(i);
      send_burst(r, 1, 0);
      if (i == 3) bus.req = 2'b00;
      wait_csn_high("rr");
      rise = cyc;
    end
    tick(); tick();

    // Throttled source: 10 idle cycles between bytes
    burst[0] = 8'h11; burst[1] = 8'h22;
    e0 = en_cyc_q.size(); c0 = csn_rise;
    bus.req[0] = 1'b1;
    tick();
    send_burst(0, 2, 10);
    bus.req[0] = 1'b0;
    wait_csn_high("throttle");
    tick(); tick();
    check("throttle enable count", 32'(en_cyc_q.size() - e0), 32'd2);
    check("throttle enable gap", 32'(en_cyc_q[e0+1] - en_cyc_q[e0]), 32'd11);
    check("throttle one csn window", 32'(csn_rise - c0), 32'd1);

    // Start timeout: engine never goes busy
    stub_dead = 1'b1;
    burst[0] = 8'h99;
    e0 = en_cyc_q.size(); r0 = rx_cyc_q.size(); k0 = err_cyc_q.size();
    bus.req[0] = 1'b1;
    tick();
    send_burst(0, 1, 0);
    bus.req[0] = 1'b0;
    wait_csn_high("timeout");
    rise = cyc;
    tick(); tick();
    stub_dead = 1'b0;
    check("timeout err count", 32'(err_cyc_q.size() - k0), 32'd1);
    check("timeout err cycle", 32'(err_cyc_q[k0] - en_cyc_q[e0]), 32'd15);
    check("timeout csn hold", 32'(rise - err_cyc_q[k0]), 32'(CS_HOLD));
    check("timeout no rx", 32'(rx_cyc_q.size() - r0), 32'd0);

    // Asynchronous reset in XFER, then priority restarts at requester 0
    burst[0] = 8'h5A;
    bus.req[0] = 1'b1;
    tick();
    send_burst(0, 1, 0);
    tick(); tick();
    check("pre-reset engine busy", 32'(bus.spi_busy), 32'd1);
    reset_n = 1'b0;
    bus.req = 2'b00;
    #1;
    check("async reset csn", 32'(bus.csn), 32'd1);
    check("async reset gnt", 32'(bus.gnt), 32'd0);
    check("async reset enable/ready", 32'({bus.spi_enable, bus.tx_ready}), 32'd0);
    check("async reset spi_tx_data", 32'(bus.spi_tx_data), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    bus.req = 2'b11;
    wait_gnt("post-reset");
    check("post-reset priority", 32'(bus.gnt), 32'b01);
    burst[0] = 8'hC3;
    send_burst(0, 1, 0);
    bus.req[0] = 1'b0;
    wait_csn_high("post-reset b0");
    wait_gnt("post-reset b1");
    check("post-reset req1 grant", 32'(bus.gnt), 32'b10);
    r0 = rx_cyc_q.size();
    burst[0] = 8'hE1;
    send_burst(1, 1, 0);
    bus.req[1] = 1'b0;
    wait_csn_high("post-reset b1");
    tick(); tick();
    check("post-reset req1 rx", 32'({rx_vec_q[r0], rx_dat_q[r0]}), 32'h21E);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
